// File: rtl/multiword_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multiword_add_sequencer
// Description : Streams multi-word operands (least-significant word first)
//               through an external combinational WIDTH-bit adder. S1 holds
//               the operand word driving the adder; S2 captures the sum.
//               Each word's carry-out is chained into the next word's
//               carry-in, giving one result word per clock.
//               Optional macro MULTIWORD_ADD_SUB_EN adds port in_sub, which
//               turns the operation into A-B (two's complement).
// Revision    : 1.0 - initial release
// ============================================================================
module multiword_add_sequencer #(
  parameter int WIDTH     = 64,
  parameter int MAX_WORDS = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
`ifdef MULTIWORD_ADD_SUB_EN
  input  logic             in_sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_last,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_last,
  output logic             out_cout,
  output logic [CNT_W-1:0] out_idx,
  output logic             out_err
);

  localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(MAX_WORDS - 1);

  // S1: operand stage feeding the adder
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic             s1_cin_q;
  logic             s1_last_q;
  logic             s1_err_q;
  logic [CNT_W-1:0] s1_idx_q;

  // S2: result stage
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_sum_q;
  logic             s2_last_q;
  logic             s2_cout_q;
  logic [CNT_W-1:0] s2_idx_q;
  logic             s2_err_q;

  // Operation tracking
  logic             first_q;
  logic             first_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             carry_hold_q;

  // Combinational helpers
  logic             w_s1_adv;
  logic             w_in_fire;
  logic [CNT_W-1:0] w_idx;
  logic             w_forced;
  logic             w_last;
  logic             w_cin;
  logic [WIDTH-1:0] w_b;

`ifdef MULTIWORD_ADD_SUB_EN
  logic             sub_q;
  logic             w_sub;
`endif

  assign w_s1_adv  = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready  = !s1_valid_q || w_s1_adv;
  assign w_in_fire = in_valid && in_ready;

  assign add_a   = s1_a_q;
  assign add_b   = s1_b_q;
  assign add_cin = s1_cin_q;

  assign out_valid = s2_valid_q;
  assign out_sum   = s2_sum_q;
  assign out_last  = s2_last_q;
  assign out_cout  = s2_cout_q;
  assign out_idx   = s2_idx_q;
  assign out_err   = s2_err_q;

  // Decode the incoming word: index, forced termination, operand B and carry-in
  always_comb begin
    w_idx    = first_q ? '0 : cnt_q;
    w_forced = (w_idx == C_LAST_IDX) && !in_last;
    w_last   = in_last || w_forced;
    first_d  = first_q;
    cnt_d    = cnt_q;
`ifdef MULTIWORD_ADD_SUB_EN
    // Subtract mode is latched on the first word and held for the operation
    w_sub = first_q ? in_sub : sub_q;
    w_b   = w_sub ? ~in_b : in_b;
    if (first_q)
      w_cin = in_sub ? 1'b1 : in_cin;
`else
    w_b = in_b;
    if (first_q)
      w_cin = in_cin;
`endif
    // A valid S1 word is always advancing when a new word is accepted,
    // so its live carry-out is the correct chain value
    else if (s1_valid_q)
      w_cin = add_cout;
    else
      w_cin = carry_hold_q;
    if (w_in_fire) begin
      first_d = w_last;
      cnt_d   = w_idx + CNT_W'(1);
    end
  end

  // S1 register: loads on an input handshake, empties when it advances
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_cin_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_idx_q   <= '0;
    end else begin
      if (w_in_fire) begin
        s1_valid_q <= 1'b1;
        s1_a_q     <= in_a;
        s1_b_q     <= w_b;
        s1_cin_q   <= w_cin;
        s1_last_q  <= w_last;
        s1_err_q   <= w_forced;
        s1_idx_q   <= w_idx;
      end else if (w_s1_adv) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  // S2 register: captures the adder result when S1 advances
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_last_q  <= 1'b0;
      s2_cout_q  <= 1'b0;
      s2_idx_q   <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        s2_valid_q <= 1'b1;
        s2_sum_q   <= add_sum;
        s2_last_q  <= s1_last_q;
        s2_cout_q  <= s1_last_q ? add_cout : 1'b0;
        s2_idx_q   <= s1_idx_q;
        s2_err_q   <= s1_err_q;
      end else if (out_ready) begin
        s2_valid_q <= 1'b0;
      end
    end
  end

  // Operation tracking: first-word flag, word counter and carry holding
  always_ff @(posedge clk) begin
    if (rst) begin
      first_q      <= 1'b1;
      cnt_q        <= '0;
      carry_hold_q <= 1'b0;
    end else begin
      first_q <= first_d;
      cnt_q   <= cnt_d;
      if (w_s1_adv)
        carry_hold_q <= add_cout;
    end
  end

`ifdef MULTIWORD_ADD_SUB_EN
  // Subtract-mode latch, captured on the first word of each operation
  always_ff @(posedge clk) begin
    if (rst)
      sub_q <= 1'b0;
    else if (w_in_fire && first_q)
      sub_q <= in_sub;
  end
`endif

endmodule
`default_nettype wire
